// File: rtl/seg7_capture_rx.sv
// Seven-segment result receiver: decodes strobed patterns, queues them in a FIFO, and keeps saturating tallies.
// Latency: a strobe sampled at edge N is counted and written to the FIFO at edge N+1.
// Backpressure: the producer is never stalled. A push into a full FIFO with no pop on the same edge is dropped and counted.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   seg_in, seg_valid     segment pattern (bit 6 = a .. bit 0 = g) and its single-cycle strobe
//   clr_cnt               synchronous clear of the four tallies
//   out_valid/out_ready   handshake for the FIFO head
//   out_code, out_is_one  head class (0 ZERO, 1 ONE, 3 INVALID) and the ONE flag
//   fifo_level            occupied entries
//   cnt_*                 saturating tallies of ONE, ZERO, INVALID and dropped results
module seg7_capture_rx #(
   parameter int ACTIVE_LOW = 1,
   parameter int DEPTH      = 4,
   parameter int CNT_BITS   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_in,
   input  logic                    seg_valid,
   input  logic                    clr_cnt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              out_code,
   output logic                    out_is_one,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [CNT_BITS-1:0]     cnt_one,
   output logic [CNT_BITS-1:0]     cnt_zero,
   output logic [CNT_BITS-1:0]     cnt_err,
   output logic [CNT_BITS-1:0]     cnt_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   // Class code 2 is never emitted, so it serves internally as the BLANK marker.
   localparam logic [1:0] C_ZERO  = 2'd0;
   localparam logic [1:0] C_ONE   = 2'd1;
   localparam logic [1:0] C_BLANK = 2'd2;
   localparam logic [1:0] C_INV   = 2'd3;

   logic [6:0]          ah;
   logic [1:0]          cls;
   logic                stg_vld_q;
   logic [1:0]          stg_code_q;
   logic [1:0]          mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]       level_q, level_d;
   logic [CNT_BITS-1:0] cnt_one_q, cnt_zero_q, cnt_err_q, cnt_drop_q;
   logic                push, pop, full, accept, drop;

   // Saturating increment. Clear takes priority over an increment on the same edge.
   function automatic logic [CNT_BITS-1:0] tally(input logic [CNT_BITS-1:0] c,
                                                 input logic inc, input logic clr);
      if (clr)
         return '0;
      else if (inc && !(&c))
         return c + CNT_BITS'(1);
      else
         return c;
   endfunction

   always_comb begin
      ah  = (ACTIVE_LOW != 0) ? ~seg_in : seg_in;
      cls = C_INV;
      case (ah)
         7'b1111110: cls = C_ZERO;
         7'b0110000: cls = C_ONE;
         7'b0000000: cls = C_BLANK;
         default:    cls = C_INV;
      endcase
   end

   always_comb begin
      push   = stg_vld_q && (stg_code_q != C_BLANK);
      pop    = out_valid && out_ready;
      full   = (level_q == FULL_LVL);
      // A pop on the same edge frees the slot, so a full FIFO can still accept.
      accept = push && (!full || pop);
      drop   = push && full && !pop;
      level_d = level_q;
      if (accept && !pop)
         level_d = level_q + LW'(1);
      else if (!accept && pop)
         level_d = level_q - LW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_vld_q  <= 1'b0;
         stg_code_q <= C_ZERO;
      end else begin
         stg_vld_q <= seg_valid;
         if (seg_valid)
            stg_code_q <= cls;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= C_ZERO;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= stg_code_q;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_one_q  <= '0;
         cnt_zero_q <= '0;
         cnt_err_q  <= '0;
         cnt_drop_q <= '0;
      end else begin
         cnt_one_q  <= tally(cnt_one_q,  push && (stg_code_q == C_ONE),  clr_cnt);
         cnt_zero_q <= tally(cnt_zero_q, push && (stg_code_q == C_ZERO), clr_cnt);
         cnt_err_q  <= tally(cnt_err_q,  push && (stg_code_q == C_INV),  clr_cnt);
         cnt_drop_q <= tally(cnt_drop_q, drop,                           clr_cnt);
      end
   end

   // The head is read straight from storage; when empty this shows the stale slot.
   assign out_valid  = (level_q != '0);
   assign out_code   = mem_q[rd_ptr_q];
   assign out_is_one = (mem_q[rd_ptr_q] == C_ONE);
   assign fifo_level = level_q;
   assign cnt_one    = cnt_one_q;
   assign cnt_zero   = cnt_zero_q;
   assign cnt_err    = cnt_err_q;
   assign cnt_drop   = cnt_drop_q;

endmodule

// File: doc/seg7_capture_rx.md
# seg7_capture_rx

Receive-side counterpart of the threshold/seven-segment result driver. Samples strobed 7-segment patterns (a..g), decodes them back to a class (ZERO, ONE, INVALID), queues results in a small FIFO behind a valid/ready output, and keeps saturating tallies. Used for loopback checking of classifier output and for feeding decoded results to a host/UART path.

## Interface
Parameters:
- ACTIVE_LOW, 1, input pattern polarity: nonzero means a lit segment is 0.
- DEPTH, 4, FIFO depth in entries; power of 2, at least 2.
- CNT_BITS, 16, width of each tally counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state.
- seg_in  in  7  segment pattern, bit 6 = a ... bit 0 = g.
- seg_valid  in  1  single-cycle strobe; seg_in is sampled only when it is high.
- clr_cnt  in  1  synchronous clear of all four counters.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready.
- out_code  out  2  head class: 0 = ZERO, 1 = ONE, 3 = INVALID; 2 is never emitted.
- out_is_one  out  1  equals (out_code == 1).
- fifo_level  out  $clog2(DEPTH)+1  number of occupied entries.
- cnt_one, cnt_zero, cnt_err, cnt_drop  out  CNT_BITS each  saturating tallies.

## Operation
- Normalize polarity: ah = ACTIVE_LOW ? ~seg_in : seg_in.
- Decode ah to a class:
  - 7'b1111110 gives ZERO.
  - 7'b0110000 gives ONE.
  - 7'b0000000 gives BLANK.
  - Any other pattern gives INVALID.
- Stage 1, on the edge where seg_valid = 1: register the class and a stage-valid bit. Stage-valid is 0 on edges where seg_valid = 0.
- Stage 2, on the next edge when stage-valid = 1:
  - BLANK: discarded. No push, no counter change.
  - ZERO, ONE or INVALID: increment cnt_zero, cnt_one or cnt_err respectively, whether or not the push is accepted.
  - The push is accepted when the FIFO is not full, or when a pop happens on the same edge.
  - When the FIFO is full and no pop happens on that edge: the entry is dropped and cnt_drop increments. FIFO contents are unchanged.
- FIFO: a circular buffer with DEPTH entries and wrapping read/write pointers.
  - out_valid = (level != 0).
  - out_code and out_is_one come from the head entry, read combinationally from storage. When out_valid = 0, they read the stale slot.
  - A pop occurs when out_valid && out_ready.
  - A pop when empty is impossible, because out_valid = 0.
  - Push and pop on the same edge: level unchanged, both pointers advance. This holds when full, and also when level = 1 (the new entry becomes the head).
- Counters saturate at 2^CNT_BITS-1 and do not wrap.
- clr_cnt on the same edge as an increment: clear wins, counter = 0. clr_cnt does not affect the FIFO or the pipeline.
- Back-to-back strobes, one every cycle, are supported: full throughput of one result per clock.

## Timing
- Reset state, immediate and asynchronous: out_valid = 0, out_code = 0, out_is_one = 0, fifo_level = 0, all counters = 0, stage-valid = 0, both pointers = 0.
- Latency: seg_valid high in the cycle ending at edge N. The counter update, FIFO write, out_valid and fifo_level all take effect after edge N+1.
- Reset asserted mid-operation discards both the staged result and the FIFO contents. The first strobe after reset release follows the normal 2-edge latency.
- out_valid depends only on registered state, with no combinational path from seg_valid. out_ready affects only the next-state logic.
- The producer does not wait: seg_valid is never back-pressured. Overflow is reported only through cnt_drop.

## Test plan
- Decode, ACTIVE_LOW = 1: strobe seg_in = 7'h4F, then 7'h01, then 7'h23, with out_ready = 1.
  - Expect out_code 1, 0, 3 on consecutive cycles, starting 2 edges after the first strobe.
  - Expect cnt_one = cnt_zero = cnt_err = 1.
- Blank filter: strobe 7'h7F three times.
  - Expect out_valid to stay 0, fifo_level = 0 and all counters = 0.
  - With ACTIVE_LOW = 0, strobe 7'h00: expect the same result.
- Overflow, DEPTH = 4: hold out_ready = 0 and strobe 6 ONE patterns back to back.
  - Expect fifo_level = 4, cnt_one = 6, cnt_drop = 2.
  - Then pop 4: expect out_code = 1 each time and fifo_level back to 0.
- Full with simultaneous push and pop: fill to 4, then assert out_ready together with one more strobe.
  - Expect fifo_level to stay 4 and cnt_drop to stay unchanged.
  - Expect the new entry to come out last when drained.
- Saturation and clear, CNT_BITS = 2: issue 5 ONE strobes.
  - Expect cnt_one = 3, not wrapped.
  - Assert clr_cnt on the same edge as the stage-2 update of a ZERO strobe: expect cnt_zero = 0 after that edge.
- Async reset mid-stream: fill to 3 entries plus one staged strobe, then pulse rst between clock edges.
  - Expect out_valid = 0, fifo_level = 0 and counters = 0 immediately, before the next edge.
  - The next strobe appears 2 edges after it is issued.
